// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Collects interrupt requests from peripherals (timer, mouse, ...) and hands
// them to the processor one at a time.
//   * A rising edge on IRQ_IN[i] latches pending[i]. The peripheral receives a
//     one-cycle IRQ_ACK_OUT[i] pulse on the same clock edge.
//   * Pending sources are masked and prioritised (index 0 is highest). The
//     winner is presented on CPU_IRQ_RAISE as a one-hot level until the CPU
//     acknowledges it or software clears its pending bit.
//   * After each presentation the raise stays low for one cycle, so the
//     processor always sees a deassertion between two interrupts.
//
// Bus register window (BaseAddr + offset):
//   +0 PENDING  read: pending bits; write: 1 clears the bit, 0 leaves it
//   +1 MASK     read/write, 1 = enabled; bits >= NumSources read 0
//   +2 STATUS   read-only: bit7 = presenting, bits[2:0] = selected index
//   +3 MISSED   read-only miss counter; any write clears it
//
// Optional feature macro IRQ_MISS_COUNT_EN:
//   defined   -> MISSED counts cycles in which at least one edge arrived on an
//                already-pending source (saturating at 8'hFF).
//   undefined -> no counter; +3 reads 8'h00 and writes to it are ignored.
//
// Bus reads are registered: an address cycle with BUS_WE=0 inside the window
// makes the block drive BUS_DATA during the next cycle only, with the register
// value of that next cycle. Otherwise BUS_DATA is high-Z.
//
// Handshake (processor side): CPU_IRQ_RAISE is a level held while presenting;
// the processor acknowledges by pulsing the matching CPU_IRQ_ACK bit for at
// least one cycle. Acks on bits other than the presented one are ignored.
// IRQ_ACK_OUT to the peripherals is a single-cycle pulse with no back-pressure.
//
// Ports:
//   CLK            system clock
//   RESET          asynchronous reset, active low
//   BUS_DATA[7:0]  shared bidirectional data bus
//   BUS_ADDR[7:0]  bus address
//   BUS_WE         bus write enable
//   IRQ_IN         peripheral interrupt-raise levels
//   IRQ_ACK_OUT    one-cycle ack pulses to the peripherals
//   CPU_IRQ_RAISE  one-hot interrupt presented to the processor
//   CPU_IRQ_ACK    one-hot processor acknowledge
// -----------------------------------------------------------------------------
module interrupt_controller #(
  parameter logic [7:0] BaseAddr    = 8'hE0,
  parameter int         NumSources  = 4,
  parameter logic [7:0] InitialMask = 8'hFF
) (
  input  logic                  CLK,
  input  logic                  RESET,
  inout  wire  [7:0]            BUS_DATA,
  input  logic [7:0]            BUS_ADDR,
  input  logic                  BUS_WE,
  input  logic [NumSources-1:0] IRQ_IN,
  output logic [NumSources-1:0] IRQ_ACK_OUT,
  output logic [NumSources-1:0] CPU_IRQ_RAISE,
  input  logic [NumSources-1:0] CPU_IRQ_ACK
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_GAP     = 2'd2;

  localparam logic [NumSources-1:0] SRC_ONE = NumSources'(1);

  logic [1:0]            state;
  logic [2:0]            sel;
  logic [NumSources-1:0] prev_q;
  logic [NumSources-1:0] pending_q;
  logic [NumSources-1:0] mask_q;
  logic [NumSources-1:0] ack_out_q;
  logic [NumSources-1:0] raise_q;
  logic                  rd_en_q;
  logic [1:0]            rd_off_q;
  logic [7:0]            missed_q;

  // ---------------------------------------------------------------------------
  // Address decode. The subtraction is done in 9 bits so that addresses below
  // BaseAddr cannot wrap into the window.
  // ---------------------------------------------------------------------------
  logic [8:0] addr_delta;
  logic       in_window;
  logic [1:0] offset;
  logic       wr_pending;
  logic       wr_mask;

  assign addr_delta = {1'b0, BUS_ADDR} - {1'b0, BaseAddr};
  assign in_window  = (addr_delta < 9'd4);
  assign offset     = addr_delta[1:0];
  assign wr_pending = BUS_WE & in_window & (offset == 2'd0);
  assign wr_mask    = BUS_WE & in_window & (offset == 2'd1);

  // Bus bits above NumSources carry nothing for PENDING/MASK writes.
  logic unused_bus_bits;
  assign unused_bus_bits = ^BUS_DATA;

  // ---------------------------------------------------------------------------
  // Edge capture and pending-bit update
  // ---------------------------------------------------------------------------
  logic [NumSources-1:0] irq_edge;
  logic [NumSources-1:0] sel_onehot;
  logic [NumSources-1:0] sw_clr;
  logic [NumSources-1:0] clr_bits;
  logic [NumSources-1:0] pending_nxt;
  logic [NumSources-1:0] eligible;
  logic                  cpu_ack_hit;
  logic                  sw_abort;

  assign irq_edge    = IRQ_IN & ~prev_q;
  assign sel_onehot  = SRC_ONE << sel;
  assign sw_clr      = wr_pending ? BUS_DATA[NumSources-1:0] : '0;
  assign cpu_ack_hit = (state == ST_PRESENT) && (|(CPU_IRQ_ACK & sel_onehot));
  assign sw_abort    = (state == ST_PRESENT) && (|(sw_clr & sel_onehot));
  assign clr_bits    = sw_clr | (cpu_ack_hit ? sel_onehot : '0);
  // A new edge beats a clear arriving in the same cycle.
  assign pending_nxt = (pending_q & ~clr_bits) | irq_edge;
  assign eligible    = pending_q & mask_q;

  // Lowest set index wins: scan from the top so the last hit is the smallest.
  logic [2:0] pick_sel;
  always_comb begin
    pick_sel = 3'd0;
    for (int i = NumSources - 1; i >= 0; i--) begin
      if (eligible[i]) pick_sel = 3'(i);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      prev_q    <= '0;
      pending_q <= '0;
      ack_out_q <= '0;
      mask_q    <= InitialMask[NumSources-1:0];
    end else begin
      prev_q    <= IRQ_IN;
      pending_q <= pending_nxt;
      ack_out_q <= irq_edge;
      if (wr_mask) mask_q <= BUS_DATA[NumSources-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Presentation FSM. The mask only gates entry from IDLE; masking the source
  // being presented does not withdraw it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= ST_IDLE;
      sel     <= 3'd0;
      raise_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|eligible) begin
            sel     <= pick_sel;
            raise_q <= SRC_ONE << pick_sel;
            state   <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (cpu_ack_hit || sw_abort) begin
            raise_q <= '0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          raise_q <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign IRQ_ACK_OUT   = ack_out_q;
  assign CPU_IRQ_RAISE = raise_q;

  // ---------------------------------------------------------------------------
  // Miss counter
  // ---------------------------------------------------------------------------
`ifdef IRQ_MISS_COUNT_EN
  logic wr_missed;
  logic miss_any;

  assign wr_missed = BUS_WE & in_window & (offset == 2'd3);
  // An edge on an already-pending source that is not being cleared this cycle.
  assign miss_any  = |(irq_edge & pending_q & ~clr_bits);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      missed_q <= 8'h00;
    end else if (wr_missed) begin
      missed_q <= 8'h00;
    end else if (miss_any && (missed_q != 8'hFF)) begin
      missed_q <= missed_q + 8'd1;
    end
  end
`else
  assign missed_q = 8'h00;
`endif

  // ---------------------------------------------------------------------------
  // Registered bus read: capture the request, drive the bus the next cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_en_q  <= 1'b0;
      rd_off_q <= 2'd0;
    end else begin
      rd_en_q  <= in_window & ~BUS_WE;
      rd_off_q <= offset;
    end
  end

  logic [7:0] rd_data;
  always_comb begin
    rd_data = 8'h00;
    case (rd_off_q)
      2'd0: rd_data = 8'(pending_q);
      2'd1: rd_data = 8'(mask_q);
      2'd2: rd_data = {(state == ST_PRESENT), 4'b0000, sel};
      2'd3: rd_data = missed_q;
      default: rd_data = 8'h00;
    endcase
  end

  assign BUS_DATA = rd_en_q ? rd_data : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
//
// Self-checking bench for interrupt_controller (default parameters,
// NumSources = 4, BaseAddr = 8'hE0). Inputs are driven 1 time unit after the
// rising clock edge; outputs are sampled at the same point, i.e. after the
// registers have settled. A register-access vector table, hand sequences for
// the multi-cycle corner cases, and a randomized phase compared cycle by cycle
// against a source-level behavioural model.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

  localparam int         N    = 4;
  localparam logic [7:0] BASE = 8'hE0;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         CLK = 1'b0;
  logic         RESET;
  wire  [7:0]   BUS_DATA;
  logic [7:0]   BUS_ADDR;
  logic         BUS_WE;
  logic [N-1:0] IRQ_IN;
  logic [N-1:0] IRQ_ACK_OUT;
  logic [N-1:0] CPU_IRQ_RAISE;
  logic [N-1:0] CPU_IRQ_ACK;
  logic         tb_drv;
  logic [7:0]   tb_dat;

  assign BUS_DATA = tb_drv ? tb_dat : 8'bzzzz_zzzz;

  always #5 CLK = ~CLK;

  interrupt_controller dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .BUS_DATA      (BUS_DATA),
    .BUS_ADDR      (BUS_ADDR),
    .BUS_WE        (BUS_WE),
    .IRQ_IN        (IRQ_IN),
    .IRQ_ACK_OUT   (IRQ_ACK_OUT),
    .CPU_IRQ_RAISE (CPU_IRQ_RAISE),
    .CPU_IRQ_ACK   (CPU_IRQ_ACK)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: per-source pending flags and "which source is being
  // shown" (-1 = none), plus one quiet cycle after every presentation.
  // ---------------------------------------------------------------------------
  logic [N-1:0] m_pend;
  logic [N-1:0] m_mask;
  logic [N-1:0] m_prev;
  logic [N-1:0] m_ack_out;
  int           m_cur;
  int           m_sel;
  bit           m_gap;
  int           m_missed;

  task automatic model_reset();
    m_pend    = '0;
    m_mask    = '1;
    m_prev    = '0;
    m_ack_out = '0;
    m_cur     = -1;
    m_sel     = 0;
    m_gap     = 1'b0;
    m_missed  = 0;
  endtask

  function automatic logic [N-1:0] m_raise();
    if (m_cur >= 0) return N'(1) << m_cur;
    return '0;
  endfunction

  function automatic logic [7:0] model_read(input int off);
    case (off)
      0:       return 8'(m_pend);
      1:       return 8'(m_mask);
      2:       return {(m_cur >= 0), 4'b0000, 3'(m_sel)};
      default: return 8'(m_missed);
    endcase
  endfunction

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    logic [N-1:0] edg;
    logic [N-1:0] clr;
    bit           wr;
    int           off;
    if (!RESET) begin
      model_reset();
      return;
    end
    wr  = BUS_WE && (BUS_ADDR >= BASE) && (BUS_ADDR <= BASE + 8'd3);
    off = int'(BUS_ADDR) - int'(BASE);
    edg = IRQ_IN & ~m_prev;
    clr = (wr && off == 0) ? tb_dat[N-1:0] : '0;
    if (m_cur >= 0 && CPU_IRQ_ACK[m_cur]) clr[m_cur] = 1'b1;
`ifdef IRQ_MISS_COUNT_EN
    begin
      bit any_miss;
      any_miss = 1'b0;
      for (int i = 0; i < N; i++) if (edg[i] && m_pend[i] && !clr[i]) any_miss = 1'b1;
      if (wr && off == 3) m_missed = 0;
      else if (any_miss && m_missed < 255) m_missed++;
    end
`endif
    // A presentation ends once its pending bit is being cleared.
    if (m_cur >= 0) begin
      if (clr[m_cur]) begin
        m_cur = -1;
        m_gap = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_pend[i] && m_mask[i]) begin
          m_cur = i;
          m_sel = i;
          break;
        end
      end
    end
    m_pend = (m_pend & ~clr) | edg;
    if (wr && off == 1) m_mask = tb_dat[N-1:0];
    m_prev    = IRQ_IN;
    m_ack_out = edg;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    BUS_ADDR = a;
    BUS_WE   = 1'b1;
    tb_dat   = d;
    tb_drv   = 1'b1;
    tick();
    BUS_WE   = 1'b0;
    tb_drv   = 1'b0;
    BUS_ADDR = 8'h00;
  endtask

  // Returns the value driven in the cycle after the address; then idles one
  // cycle so the DUT has released the bus before the next access.
  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    BUS_ADDR = a;
    BUS_WE   = 1'b0;
    tick();
    d        = BUS_DATA;
    BUS_ADDR = 8'h00;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Register access vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    string      name;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic [7:0] raddr;
    logic [7:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[9];

  task automatic set_vec(input int idx, input string nm, input logic [7:0] wa,
                         input logic [7:0] wd, input logic [7:0] ra, input logic [7:0] ex);
    vecs[idx].name  = nm;
    vecs[idx].waddr = wa;
    vecs[idx].wdata = wd;
    vecs[idx].raddr = ra;
    vecs[idx].exp   = ex;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  logic [7:0] rd;
  logic [7:0] exp_missed;
  int         r;
  int         rd_off;
  bit         do_read;
  bit         last_read;

  initial begin
    set_vec(0, "mask_f5",       8'hE1, 8'hF5, 8'hE1, 8'h05);
    set_vec(1, "mask_00",       8'hE1, 8'h00, 8'hE1, 8'h00);
    set_vec(2, "mask_0a",       8'hE1, 8'h0A, 8'hE1, 8'h0A);
    set_vec(3, "pend_clr_idle", 8'hE0, 8'hFF, 8'hE0, 8'h00);
    set_vec(4, "status_ro",     8'hE2, 8'hFF, 8'hE2, 8'h00);
    set_vec(5, "missed_wr",     8'hE3, 8'h77, 8'hE3, 8'h00);
    set_vec(6, "mask_0f",       8'hE1, 8'h0F, 8'hE1, 8'h0F);
    set_vec(7, "wr_above_win",  8'hE4, 8'h00, 8'hE1, 8'h0F);
    set_vec(8, "wr_below_win",  8'hDF, 8'h00, 8'hE1, 8'h0F);

    RESET       = 1'b0;
    BUS_ADDR    = 8'h00;
    BUS_WE      = 1'b0;
    IRQ_IN      = '0;
    CPU_IRQ_ACK = '0;
    tb_drv      = 1'b0;
    tb_dat      = 8'h00;
    model_reset();

    // ---- reset state ----
    tick();
    tick();
    chk("rst_irq_ack_out", 8'(IRQ_ACK_OUT), 8'h00);
    chk("rst_cpu_raise", 8'(CPU_IRQ_RAISE), 8'h00);
    RESET = 1'b1;
    tb_dat = 8'h3C;
    tb_drv = 1'b1;
    #1;
    chk("rst_bus_released", BUS_DATA, 8'h3C);
    tb_drv = 1'b0;
    bus_read(8'hE1, rd); chk("rst_mask", rd, 8'h0F);
    bus_read(8'hE3, rd); chk("rst_missed", rd, 8'h00);
    bus_read(8'hE0, rd); chk("rst_pending", rd, 8'h00);
    bus_read(8'hE2, rd); chk("rst_status", rd, 8'h00);

    // ---- register vectors ----
    foreach (vecs[i]) begin
      bus_write(vecs[i].waddr, vecs[i].wdata);
      bus_read(vecs[i].raddr, rd);
      chk(vecs[i].name, rd, vecs[i].exp);
    end

    // Read outside the window must leave the bus to other drivers.
    BUS_ADDR = 8'hE4;
    tick();
    BUS_ADDR = 8'h00;
    tb_dat = 8'hC3;
    tb_drv = 1'b1;
    #1;
    chk("oow_read_released", BUS_DATA, 8'hC3);
    tb_drv = 1'b0;
    tick();

    // ---- single source 2: edge, present, stray ack, real ack ----
    IRQ_IN = 4'b0100;
    tick();
    chk("s2_ack_pulse", 8'(IRQ_ACK_OUT), 8'h04);
    chk("s2_raise_not_yet", 8'(CPU_IRQ_RAISE), 8'h00);
    tick();
    chk("s2_ack_one_cycle", 8'(IRQ_ACK_OUT), 8'h00);
    chk("s2_raise", 8'(CPU_IRQ_RAISE), 8'h04);
    CPU_IRQ_ACK = 4'b0001;
    tick();
    CPU_IRQ_ACK = '0;
    chk("s2_stray_ack_ignored", 8'(CPU_IRQ_RAISE), 8'h04);
    bus_read(8'hE2, rd); chk("s2_status_presenting", rd, 8'h82);
    CPU_IRQ_ACK = 4'b0100;
    tick();
    CPU_IRQ_ACK = '0;
    chk("s2_raise_dropped", 8'(CPU_IRQ_RAISE), 8'h00);
    bus_read(8'hE0, rd); chk("s2_pending_cleared", rd, 8'h00);
    IRQ_IN = '0;
    tick();

    // ---- simultaneous edges on 3 and 1: priority and gap ----
    IRQ_IN = 4'b1010;
    tick();
    chk("p_ack_both", 8'(IRQ_ACK_OUT), 8'h0A);
    tick();
    chk("p_first_src1", 8'(CPU_IRQ_RAISE), 8'h02);
    CPU_IRQ_ACK = 4'b0010;
    tick();
    CPU_IRQ_ACK = '0;
    chk("p_gap_a", 8'(CPU_IRQ_RAISE), 8'h00);
    tick();
    chk("p_gap_b", 8'(CPU_IRQ_RAISE), 8'h00);
    tick();
    chk("p_second_src3", 8'(CPU_IRQ_RAISE), 8'h08);
    CPU_IRQ_ACK = 4'b1000;
    tick();
    CPU_IRQ_ACK = '0;
    IRQ_IN = '0;
    tick();
    tick();

    // ---- masked source held pending, then unmasked ----
    bus_write(8'hE1, 8'h0D);
    IRQ_IN = 4'b0010;
    tick();
    tick();
    chk("m_masked_no_raise", 8'(CPU_IRQ_RAISE), 8'h00);
    bus_read(8'hE0, rd); chk("m_pending_02", rd, 8'h02);
    bus_write(8'hE1, 8'h0F);
    chk("m_unmask_cycle1", 8'(CPU_IRQ_RAISE), 8'h00);
    tick();
    chk("m_unmask_cycle2", 8'(CPU_IRQ_RAISE), 8'h02);
    CPU_IRQ_ACK = 4'b0010;
    tick();
    CPU_IRQ_ACK = '0;
    IRQ_IN = '0;
    tick();
    tick();

    // ---- software abort of presented source 0 ----
    IRQ_IN = 4'b0001;
    tick();
    tick();
    chk("a_raise_src0", 8'(CPU_IRQ_RAISE), 8'h01);
    bus_write(8'hE0, 8'h01);
    chk("a_raise_dropped", 8'(CPU_IRQ_RAISE), 8'h00);
    IRQ_IN = '0;
    bus_read(8'hE2, rd); chk("a_status_idle", rd, 8'h00);

    // ---- misses: three edges on source 0, no CPU ack ----
    IRQ_IN = 4'b0001; tick();
    IRQ_IN = 4'b0000; tick();
    IRQ_IN = 4'b0001; tick();
    IRQ_IN = 4'b0000; tick();
    IRQ_IN = 4'b0001; tick();
    chk("x_missed_edge_acked", 8'(IRQ_ACK_OUT), 8'h01);
    IRQ_IN = 4'b0000; tick();
    chk("x_raise_held", 8'(CPU_IRQ_RAISE), 8'h01);
    bus_read(8'hE0, rd); chk("x_pending", rd, 8'h01);
`ifdef IRQ_MISS_COUNT_EN
    exp_missed = 8'h02;
`else
    exp_missed = 8'h00;
`endif
    bus_read(8'hE3, rd); chk("x_missed_count", rd, exp_missed);
    bus_write(8'hE3, 8'h00);
    bus_read(8'hE3, rd); chk("x_missed_cleared", rd, 8'h00);
    CPU_IRQ_ACK = 4'b0001;
    tick();
    CPU_IRQ_ACK = '0;
    chk("x_acked", 8'(CPU_IRQ_RAISE), 8'h00);
    tick();
    tick();

    // ---- edge on presented source in the same cycle as its ack ----
    IRQ_IN = 4'b0001;
    tick();
    tick();
    chk("g_present", 8'(CPU_IRQ_RAISE), 8'h01);
    IRQ_IN = 4'b0000;
    tick();
    IRQ_IN = 4'b0001;
    CPU_IRQ_ACK = 4'b0001;
    tick();
    CPU_IRQ_ACK = '0;
    chk("g_ack_drop", 8'(CPU_IRQ_RAISE), 8'h00);
    chk("g_edge_acked", 8'(IRQ_ACK_OUT), 8'h01);
    tick();
    chk("g_gap", 8'(CPU_IRQ_RAISE), 8'h00);
    tick();
    chk("g_represent", 8'(CPU_IRQ_RAISE), 8'h01);

    // ---- mask change while presenting, then async reset ----
    bus_write(8'hE1, 8'h0E);
    chk("h_mask_no_abort", 8'(CPU_IRQ_RAISE), 8'h01);
    IRQ_IN = '0;
    RESET = 1'b0;
    #1;
    chk("h_async_drop", 8'(CPU_IRQ_RAISE), 8'h00);
    tick();
    RESET = 1'b1;
    bus_read(8'hE0, rd); chk("h_pending_reset", rd, 8'h00);
    bus_read(8'hE1, rd); chk("h_mask_reset", rd, 8'h0F);

    // ---- randomized phase against the model ----
    last_read = 1'b0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) IRQ_IN[i] = ~IRQ_IN[i];
      end
      r = $urandom_range(0, 9);
      if (r < 3 && m_cur >= 0) CPU_IRQ_ACK = N'(1) << m_cur;
      else if (r == 3)         CPU_IRQ_ACK = N'(1) << $urandom_range(0, N - 1);
      else                     CPU_IRQ_ACK = '0;

      BUS_WE   = 1'b0;
      tb_drv   = 1'b0;
      BUS_ADDR = 8'h10;
      do_read  = 1'b0;
      r = $urandom_range(0, 11);
      if (r <= 1 && !last_read) begin
        BUS_WE = 1'b1; tb_drv = 1'b1; BUS_ADDR = BASE;
        tb_dat = 8'($urandom_range(0, 255));
      end else if (r == 2 && !last_read) begin
        BUS_WE = 1'b1; tb_drv = 1'b1; BUS_ADDR = BASE + 8'd1;
        tb_dat = 8'($urandom_range(0, 255));
      end else if (r == 3 && !last_read) begin
        BUS_WE = 1'b1; tb_drv = 1'b1; BUS_ADDR = BASE + 8'd3;
        tb_dat = 8'($urandom_range(0, 255));
      end else if (r >= 4 && r <= 7) begin
        rd_off   = $urandom_range(0, 3);
        BUS_ADDR = BASE + 8'(rd_off);
        do_read  = 1'b1;
      end
      tick();
      chk("rnd_irq_ack_out", 8'(IRQ_ACK_OUT), 8'(m_ack_out));
      chk("rnd_cpu_raise", 8'(CPU_IRQ_RAISE), 8'(m_raise()));
      if (do_read) chk("rnd_bus_read", BUS_DATA, model_read(rd_off));
      last_read = do_read;
    end
    BUS_WE      = 1'b0;
    tb_drv      = 1'b0;
    BUS_ADDR    = 8'h00;
    CPU_IRQ_ACK = '0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
